// File: rtl/sub_serial_if.sv
// Start/done handshake bundle for the bit-serial subtractor: operands in, result and flags out.
interface sub_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, ripple borrow held in a flop.
// Optional macro SUB_SATURATE_EN clamps diff to 0 whenever the final borrow is set.
module sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    sub_serial_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             br;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    logic             accept;
    logic             last;
    logic             bit_d;
    logic             br_nxt;
    logic [WIDTH-1:0] full_diff;
    logic [WIDTH-1:0] diff_load;

    // Starts are honoured only when no subtraction is in flight.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(WIDTH - 1));

    // One full-subtractor slice on the current LSBs.
    assign bit_d     = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign full_diff = {bit_d, res_sh[WIDTH-1:1]};

`ifdef SUB_SATURATE_EN
    assign diff_load = br_nxt ? '0 : full_diff;
`else
    assign diff_load = full_diff;
`endif

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every flop below uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            cnt  <= '0;
            br   <= 1'b0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= full_diff;
            cnt    <= cnt + CW'(1);
            br     <= br_nxt;
            // Zero is judged on the value actually loaded, so saturation reports zero=1.
            if (last) begin
                diff_q   <= diff_load;
                borrow_q <= br_nxt;
                zero_q   <= (diff_load == '0);
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: cycle-level reference model, directed cases, random traffic.
module tb_sub_serial;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sub_serial_if #(.WIDTH(WIDTH)) bus();

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a job accepted on an edge finishes WIDTH cycles later; results from plain arithmetic.
    int               m_left;
    logic             m_done;
    logic [WIDTH-1:0] m_a, m_b, m_diff;
    logic             m_borrow, m_zero;

    function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = x - y;
`ifdef SUB_SATURATE_EN
        if (x < y) r = '0;
`endif
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_a      <= '0;
            m_b      <= '0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_zero   <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_diff   <= ref_diff(m_a, m_b);
                m_borrow <= (m_a < m_b);
                m_zero   <= (ref_diff(m_a, m_b) == '0);
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_a    <= bus.a;
                m_b    <= bus.b;
                m_left <= WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   {31'd0, bus.busy},   {31'd0, m_left > 0});
            check("done",   {31'd0, bus.done},   {31'd0, m_done});
            check("diff",   {16'd0, bus.diff},   {16'd0, m_diff});
            check("borrow", {31'd0, bus.borrow}, {31'd0, m_borrow});
            check("zero",   {31'd0, bus.zero},   {31'd0, m_zero});
        end
    end

    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
    endtask

    // Counts cycles after the accepting edge until done; optionally injects a start pulse mid-run.
    task automatic wait_done(input bit hold, input int pulse_at, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold) bus.start = 1'b0;
            if (pulse_at != 0 && n == pulse_at) begin
                bus.start = 1'b1;
                bus.a     = 16'hFFFF;
                bus.b     = 16'h0000;
            end
            if (pulse_at != 0 && n == pulse_at + 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
        end while (!bus.done && n < 60);
        check("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    int n, bn, seen_done;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #12;
        check("rst_busy",   {31'd0, bus.busy},   32'd0);
        check("rst_done",   {31'd0, bus.done},   32'd0);
        check("rst_diff",   {16'd0, bus.diff},   32'd0);
        check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
        check("rst_zero",   {31'd0, bus.zero},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        launch(16'h1234, 16'h0034);
        wait_done(1'b0, 0, n, bn);
        check("t1_latency", n, 32'd17);
        check("t1_busy_cycles", bn, 32'd16);
        check("t1_diff", {16'd0, bus.diff}, 32'h1200);
        check("t1_borrow", {31'd0, bus.borrow}, 32'd0);
        check("t1_zero", {31'd0, bus.zero}, 32'd0);
        check("t1_busy_in_done", {31'd0, bus.busy}, 32'd0);

        launch(16'h0000, 16'h0001);
        wait_done(1'b0, 0, n, bn);
`ifdef SUB_SATURATE_EN
        check("t2_diff", {16'd0, bus.diff}, 32'h0000);
        check("t2_zero", {31'd0, bus.zero}, 32'd1);
`else
        check("t2_diff", {16'd0, bus.diff}, 32'hFFFF);
        check("t2_zero", {31'd0, bus.zero}, 32'd0);
`endif
        check("t2_borrow", {31'd0, bus.borrow}, 32'd1);

        launch(16'hABCD, 16'hABCD);
        wait_done(1'b0, 0, n, bn);
        check("t3_diff", {16'd0, bus.diff}, 32'h0000);
        check("t3_borrow", {31'd0, bus.borrow}, 32'd0);
        check("t3_zero", {31'd0, bus.zero}, 32'd1);

        launch(16'h0010, 16'h0001);
        wait_done(1'b0, 5, n, bn);
        check("t4_latency", n, 32'd17);
        check("t4_diff", {16'd0, bus.diff}, 32'h000F);
        @(negedge clk);
        check("t4_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("t4_idle_done", {31'd0, bus.done}, 32'd0);

        launch(16'h8000, 16'h0001);
        wait_done(1'b1, 0, n, bn);
        check("t5a_latency", n, 32'd17);
        check("t5a_diff", {16'd0, bus.diff}, 32'h7FFF);
        check("t5a_borrow", {31'd0, bus.borrow}, 32'd0);
        bus.a = 16'h0005;
        bus.b = 16'h0007;
        wait_done(1'b0, 0, n, bn);
        check("t5b_latency", n + 17, 32'd34);
        check("t5b_diff", {16'd0, bus.diff}, 32'hFFFE);
        check("t5b_borrow", {31'd0, bus.borrow}, 32'd1);

        launch(16'h4444, 16'h1111);
        repeat (8) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("t6_busy",   {31'd0, bus.busy},   32'd0);
        check("t6_done",   {31'd0, bus.done},   32'd0);
        check("t6_diff",   {16'd0, bus.diff},   32'd0);
        check("t6_borrow", {31'd0, bus.borrow}, 32'd0);
        check("t6_zero",   {31'd0, bus.zero},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("t6_no_done_after_rst", seen_done, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: begin bus.a = 16'($urandom); bus.b = bus.a; end
                1: begin bus.a = 16'h0000; bus.b = 16'($urandom); end
                2: begin bus.a = 16'($urandom); bus.b = 16'hFFFF; end
                3: begin bus.a = 16'hFFFF; bus.b = 16'h0000; end
                default: begin bus.a = 16'($urandom); bus.b = 16'($urandom); end
            endcase
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial 16-bit unsigned subtractor for the calculator datapath. It computes a − b one bit per clock with a ripple borrow held in a flop, under a start/done handshake. It is the inverse-direction companion of the combinational adder: the SUB and compare operations use this block. Result, borrow and zero flags are registered and held until the next accepted start.

## Interface
- WIDTH, 16, operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; sampled with an accepted start.
- b  input  WIDTH  subtrahend; sampled with an accepted start.
- busy  output  1  high while the subtraction is running.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  a − b mod 2^WIDTH (saturated when SUB_SATURATE_EN is defined).
- borrow  output  1  1 when a < b (unsigned).
- zero  output  1  1 when diff == 0.

## Operation
- There is one clock domain. Reset is asynchronous and active-high. Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, internal shift registers, bit counter and borrow flop all 0.
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN when start=1. On that edge:
  - latch a and b into shift registers;
  - clear the counter and the borrow flop.
- RUN, each cycle, with bit i = LSB of each shift register and br = borrow flop:
  - d = a_i ^ b_i ^ br;
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  - d shifts into the MSB of the result register; operands shift right; counter increments.
- RUN → DONE after exactly WIDTH bit-cycles, when counter == WIDTH−1 on that edge.
  - diff is loaded from the result register plus the final d.
  - borrow is loaded from the final br'.
  - zero is loaded as diff==0, computed on the value actually driven on diff.
- DONE lasts one cycle.
  - With start=1: go to RUN with new operands (back-to-back). done still pulses this cycle.
  - Otherwise go to IDLE.
- start in RUN is ignored; operands are not re-sampled.
- diff, borrow and zero hold their values through IDLE and RUN until the next DONE overwrites them.
- Reset mid-RUN aborts the operation. All outputs return to reset values immediately (asynchronous); no done is produced.

## Timing
- Start sampled at edge 0 → busy=1 in cycles 1..WIDTH (16).
- done=1 and the new diff/borrow/zero are visible in cycle WIDTH+1 (17).
- busy=0 in DONE.
- Latency from start edge to done is WIDTH+1 cycles. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- done is never high for two consecutive cycles.

## Configuration
- SUB_SATURATE_EN defined: when the final borrow=1, diff loads 0 instead of the wrapped value. borrow still reports 1, and zero=1.
- SUB_SATURATE_EN undefined: diff is always a − b mod 2^WIDTH, and zero reflects that wrapped value.

## Test plan
- a=0x1234, b=0x0034, start one cycle → done in cycle 17; diff=0x1200, borrow=0, zero=0; busy high for exactly 16 cycles.
- a=0x0000, b=0x0001:
  - without macro → diff=0xFFFF, borrow=1, zero=0;
  - with SUB_SATURATE_EN → diff=0x0000, borrow=1, zero=1.
- a=0xABCD, b=0xABCD → diff=0x0000, borrow=0, zero=1.
- Start 0x0010−0x0001. Pulse start with a=0xFFFF, b=0 at cycle 5 (mid-RUN). The pulse is ignored: result 0x000F at cycle 17, then IDLE.
- Back-to-back: start held high with 0x8000−0x0001, then 0x0005−0x0007 presented in the DONE cycle.
  - First done at cycle 17: diff=0x7FFF, borrow=0.
  - Second done at cycle 34: diff=0xFFFE, borrow=1.
- Assert rst at cycle 8 of a run → busy, done, diff, borrow and zero go to 0 immediately. After release, no done appears until a new start.
